// File: rtl/prog_loader_rom.sv
// prog_loader_rom: program store and byte-wise loader for the control unit.
// Accepts a DEPTH-byte image plus a trailing checksum, holds the CPU in reset
// until a good image is present, then serves instruction bytes by PC.
//
// state | meaning
// IDLE  | no image; waiting for load_start_pm
// LOAD  | accepting program bytes into mem
// CHECK | waiting for the checksum byte
// RUN   | image good; CPU released, instructions served
// ERR   | checksum mismatch; CPU held, waiting for a new load
module prog_loader_rom #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk_pm,
  input  logic              rst_pm,
  input  logic              load_start_pm,
  input  logic              ld_valid_pm,
  input  logic [DATA_W-1:0] ld_data_pm,
  output logic              ld_ready_pm,
  output logic [ADDR_W:0]   ld_count_pm,
  output logic              load_done_pm,
  output logic              load_err_pm,
  output logic              cpu_rst_pm,
  input  logic [ADDR_W-1:0] pc_pm,
  output logic [DATA_W-1:0] instruction_pm
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CHECK = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam logic [ADDR_W:0] LAST_WPTR = (ADDR_W+1)'(DEPTH-1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              mem_we;
  logic              xfer;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign xfer = ld_valid_pm & ready_q;

  // Next-state, pointer and checksum accumulation; load_start_pm wins over any transfer.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    sum_d   = sum_q;
    done_d  = done_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    if (load_start_pm) begin
      state_d = LOAD;
      wptr_d  = '0;
      sum_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (xfer) begin
            mem_we = 1'b1;
            sum_d  = sum_q + ld_data_pm;
            wptr_d = wptr_q + 1'b1;
            if (wptr_q == LAST_WPTR) state_d = CHECK;
          end
        end
        CHECK: begin
          if (xfer) begin
            if (ld_data_pm == sum_q) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ERR;
              err_d   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output flags are decoded from the state being entered so they are plain flops.
  always_comb begin
    ready_d   = (state_d == LOAD) || (state_d == CHECK);
    cpu_rst_d = (state_d != RUN);
  end

  // State, flags and program memory; reset also wipes the image to NOPs.
  always_ff @(posedge clk_pm) begin
    if (!rst_pm) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      sum_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      sum_q     <= sum_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      cpu_rst_q <= cpu_rst_d;
      if (mem_we) mem_q[wptr_q[ADDR_W-1:0]] <= ld_data_pm;
    end
  end

  // Zero-latency instruction fetch; NOP whenever the image is not running.
  always_comb begin
    instruction_pm = (state_q == RUN) ? mem_q[pc_pm] : '0;
  end

  assign ld_ready_pm  = ready_q;
  assign ld_count_pm  = wptr_q;
  assign load_done_pm = done_q;
  assign load_err_pm  = err_q;
  assign cpu_rst_pm   = cpu_rst_q;

endmodule

// File: tb/tb_prog_loader_rom.sv
// Directed bench for prog_loader_rom.
module tb_prog_loader_rom;

  logic       clk_pm = 1'b0;
  logic       rst_pm = 1'b0;
  logic       load_start_pm = 1'b0;
  logic       ld_valid_pm = 1'b0;
  logic [7:0] ld_data_pm = 8'h00;
  logic       ld_ready_pm;
  logic [4:0] ld_count_pm;
  logic       load_done_pm;
  logic       load_err_pm;
  logic       cpu_rst_pm;
  logic [3:0] pc_pm = 4'd0;
  logic [7:0] instruction_pm;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] img [16];

  prog_loader_rom dut (
    .clk_pm(clk_pm), .rst_pm(rst_pm), .load_start_pm(load_start_pm),
    .ld_valid_pm(ld_valid_pm), .ld_data_pm(ld_data_pm), .ld_ready_pm(ld_ready_pm),
    .ld_count_pm(ld_count_pm), .load_done_pm(load_done_pm), .load_err_pm(load_err_pm),
    .cpu_rst_pm(cpu_rst_pm), .pc_pm(pc_pm), .instruction_pm(instruction_pm)
  );

  always #5 clk_pm = ~clk_pm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pm);
    #1;
  endtask

  // Optional start pulse, 16 image bytes (optionally with an idle cycle before each), checksum.
  task automatic load_img(input bit do_start, input bit gaps, input logic [7:0] csum);
    if (do_start) begin
      load_start_pm = 1'b1;
      step();
      load_start_pm = 1'b0;
      chk("start_ready", ld_ready_pm, 1);
      chk("start_count", ld_count_pm, 0);
      chk("start_cpurst", cpu_rst_pm, 1);
    end
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        ld_valid_pm = 1'b0;
        step();
        chk("gap_count", ld_count_pm, i);
      end
      ld_valid_pm = 1'b1;
      ld_data_pm  = img[i];
      step();
      if (gaps) chk("xfer_count", ld_count_pm, i + 1);
    end
    ld_valid_pm = 1'b0;
    chk("count16", ld_count_pm, 16);
    chk("check_ready", ld_ready_pm, 1);
    ld_valid_pm = 1'b1;
    ld_data_pm  = csum;
    step();
    ld_valid_pm = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) img[i] = 8'h10 + 8'(i);

    // Reset held for two cycles
    rst_pm = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      pc_pm = 4'(c * 5 + 3);
      #1;
      chk("rst_cpurst", cpu_rst_pm, 1);
      chk("rst_ready", ld_ready_pm, 0);
      chk("rst_count", ld_count_pm, 0);
      chk("rst_done", load_done_pm, 0);
      chk("rst_instr", instruction_pm, 0);
    end
    rst_pm = 1'b1;
    step();

    // Good back-to-back load
    load_img(1'b1, 1'b0, 8'h78);
    pc_pm = 4'd3;
    #1;
    chk("good_done", load_done_pm, 1);
    chk("good_err", load_err_pm, 0);
    chk("good_cpurst", cpu_rst_pm, 0);
    chk("good_ready", ld_ready_pm, 0);
    chk("good_instr3", instruction_pm, 8'h13);

    // Bad checksum
    load_img(1'b1, 1'b0, 8'h77);
    #1;
    chk("bad_err", load_err_pm, 1);
    chk("bad_done", load_done_pm, 0);
    chk("bad_cpurst", cpu_rst_pm, 1);
    chk("bad_instr3", instruction_pm, 0);
    step();
    chk("err_sticky", load_err_pm, 1);

    // Gappy load gives the same image
    load_img(1'b1, 1'b1, 8'h78);
    chk("gap_done", load_done_pm, 1);
    chk("gap_err", load_err_pm, 0);
    chk("gap_cpurst", cpu_rst_pm, 0);
    for (int p = 0; p < 16; p++) begin
      pc_pm = 4'(p);
      #1;
      chk("gap_instr", instruction_pm, 8'h10 + 8'(p));
    end

    // Restart from RUN, 7 bytes, then start collides with a 0xAA transfer
    load_start_pm = 1'b1;
    step();
    load_start_pm = 1'b0;
    chk("rerun_cpurst", cpu_rst_pm, 1);
    chk("rerun_done", load_done_pm, 0);
    chk("rerun_instr", instruction_pm, 0);
    for (int i = 0; i < 7; i++) begin
      ld_valid_pm = 1'b1;
      ld_data_pm  = img[i];
      step();
    end
    chk("part_count", ld_count_pm, 7);
    load_start_pm = 1'b1;
    ld_data_pm    = 8'hAA;
    step();
    load_start_pm = 1'b0;
    ld_valid_pm   = 1'b0;
    chk("restart_count", ld_count_pm, 0);
    chk("restart_ready", ld_ready_pm, 1);
    load_img(1'b0, 1'b0, 8'h78);
    chk("restart_done", load_done_pm, 1);
    pc_pm = 4'd0;
    #1;
    chk("restart_instr0", instruction_pm, 8'h10);
    pc_pm = 4'd7;
    #1;
    chk("restart_instr7", instruction_pm, 8'h17);

    // Reset while running, then an all-zero image
    rst_pm = 1'b0;
    step();
    rst_pm = 1'b1;
    chk("runrst_cpurst", cpu_rst_pm, 1);
    chk("runrst_done", load_done_pm, 0);
    chk("runrst_count", ld_count_pm, 0);
    chk("runrst_instr", instruction_pm, 0);
    step();
    chk("idle_ready", ld_ready_pm, 0);
    for (int i = 0; i < 16; i++) img[i] = 8'h00;
    load_img(1'b1, 1'b0, 8'h00);
    chk("zero_done", load_done_pm, 1);
    chk("zero_cpurst", cpu_rst_pm, 0);
    for (int p = 0; p < 16; p++) begin
      pc_pm = 4'(p);
      #1;
      chk("zero_instr", instruction_pm, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader_rom.md
Name: prog_loader_rom

Overview:
- Program store and loader sitting directly upstream of the control unit.
- Holds the 16 x 8-bit program, accepts it byte-by-byte over a valid/ready load port, and checks a trailing checksum byte.
- Holds the CPU in reset until a good image is loaded, then releases it.
- Serves the instruction byte combinationally for the CPU's 4-bit PC.

Parameters:
- ADDR_W, 4, program address width; matches the CPU PC width.
- DATA_W, 8, instruction and load-byte width.
- DEPTH, 16, number of program words; equals 2**ADDR_W.

Ports:
- clk_pm  input  1  system clock; all state updates on its rising edge.
- rst_pm  input  1  reset, synchronous, active-low.
- load_start_pm  input  1  one-cycle pulse; starts or restarts an image load.
- ld_valid_pm  input  1  load byte valid.
- ld_data_pm  input  DATA_W  load byte.
- ld_ready_pm  output  1  loader accepts a byte this cycle. A transfer occurs when ld_valid_pm=1 and ld_ready_pm=1.
- ld_count_pm  output  ADDR_W+1  number of program bytes accepted in the current load.
- load_done_pm  output  1  good image loaded; sticky until the next load_start_pm.
- load_err_pm  output  1  checksum mismatch; sticky until the next load_start_pm.
- cpu_rst_pm  output  1  active-high reset to the control unit's reset input.
- pc_pm  input  ADDR_W  program counter from the control unit.
- instruction_pm  output  DATA_W  instruction byte to the control unit.

Behaviour:
- State machine: IDLE, LOAD, CHECK, RUN, ERR.
- Registers: wptr (ADDR_W+1 bits), sum (DATA_W bits, modulo 2**DATA_W).
- Reset (rst_pm=0 at a clock edge), from any state including mid-load or RUN:
  - state=IDLE; all mem words=0x00 (NOP); wptr=0; sum=0.
  - ld_ready_pm=0, load_done_pm=0, load_err_pm=0, cpu_rst_pm=1, ld_count_pm=0.
- All outputs except instruction_pm are registered and reflect the state entered at the previous edge.
- instruction_pm is combinational and has zero latency:
  - RUN: mem[pc_pm].
  - Any other state: 0x00.
  - It must be stable for as long as pc_pm is stable, because the control unit uses it across multiple states.
- IDLE:
  - ld_ready_pm=0, cpu_rst_pm=1.
  - load_start_pm=1 -> LOAD; wptr=0; sum=0; load_done_pm=0; load_err_pm=0.
- LOAD:
  - ld_ready_pm=1, cpu_rst_pm=1.
  - On a transfer: mem[wptr]=ld_data_pm; sum=sum+ld_data_pm; wptr=wptr+1.
  - The transfer with wptr=DEPTH-1 moves the FSM to CHECK (wptr becomes DEPTH).
  - No transfer -> no change (back-pressure-free; gaps in ld_valid_pm are allowed).
- CHECK:
  - ld_ready_pm=1; the next transfer is the checksum byte and is not written to mem.
  - ld_data_pm==sum -> RUN with load_done_pm=1.
  - Otherwise -> ERR with load_err_pm=1.
- RUN:
  - ld_ready_pm=0; cpu_rst_pm=0 from the first cycle in RUN onward.
  - load_start_pm=1 -> LOAD with the same initialisation as from IDLE. cpu_rst_pm returns to 1 in the next cycle, and mem is overwritten as the new load proceeds.
- ERR:
  - ld_ready_pm=0, cpu_rst_pm=1, instruction_pm=0x00.
  - Only load_start_pm or reset leaves ERR.
- load_start_pm in LOAD or CHECK restarts the load: wptr=0, sum=0, state=LOAD.
- load_start_pm has priority over a simultaneous transfer; that byte is dropped and not written.
- ld_count_pm = wptr, saturating at DEPTH.
- pc_pm values are always in range; there is no wrap logic beyond the ADDR_W bit width.
- Checksum is the plain 8-bit sum of the DEPTH program bytes, with carry discarded.

Test Plan:
- Hold rst_pm=0 for 2 cycles. Expect: cpu_rst_pm=1, ld_ready_pm=0, ld_count_pm=0, load_done_pm=0, instruction_pm=0x00 for any pc_pm.
- Pulse load_start_pm, stream bytes 0x10..0x1F back-to-back, then checksum 0x78. Expect: ld_count_pm=16, load_done_pm=1, cpu_rst_pm=0 the cycle after the checksum. With pc_pm=3, instruction_pm=0x13 in the same cycle.
- Same image with checksum 0x77. Expect: load_err_pm=1, load_done_pm=0, cpu_rst_pm stays 1, instruction_pm=0x00 for pc_pm=3.
- Load with ld_valid_pm low on alternate cycles. Expect: ld_count_pm increments only on transfer cycles, and the final image and load_done_pm are identical to the back-to-back case.
- After 7 accepted bytes, assert load_start_pm together with ld_valid_pm (data 0xAA). Expect: ld_count_pm=0, the 0xAA byte is not stored, and a subsequent full load with the correct checksum succeeds.
- In RUN with the image loaded, drive rst_pm=0 for one cycle. Expect: cpu_rst_pm=1, IDLE, and after a later empty load (16 x 0x00, checksum 0x00) in RUN, instruction_pm=0x00 at every pc_pm.
